// File: rtl/uart_tx_8051_pkg.sv
// Shared types and constants for the 8051 serial-port transmitter (SCON mode 1).
// The TB8 state exists in the enum for all builds; it is only reachable with UART_TB8_EN.
package uart8051_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        TB8,
        STOP
    } tx_state_e;

    localparam logic [7:0] SCON_ADDR = 8'h98;
    localparam logic [7:0] SBUF_ADDR = 8'h99;
    localparam logic       TXD_IDLE  = 1'b1;

    localparam int unsigned DATA_BITS = 8;
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    // Address decode helper for the SFR bus wrapper that feeds this block.
    function automatic logic is_uart_sfr(input logic [7:0] addr);
        return (addr == SCON_ADDR) || (addr == SBUF_ADDR);
    endfunction

endpackage

// File: rtl/uart_tx_8051_if.sv
// Core-side handshake and line outputs of the 8051 UART transmitter.
// tb8 is present only when UART_TB8_EN is defined.
interface uart_tx_8051_if;

    logic       sbuf_we;
    logic [7:0] sbuf_wdata;
    logic       ti_clr;
`ifdef UART_TB8_EN
    logic       tb8;
`endif
    logic       txd;
    logic       ti;
    logic       busy;

    modport master (
`ifdef UART_TB8_EN
        output tb8,
`endif
        output sbuf_we,
        output sbuf_wdata,
        output ti_clr,
        input  txd,
        input  ti,
        input  busy
    );

    modport slave (
`ifdef UART_TB8_EN
        input  tb8,
`endif
        input  sbuf_we,
        input  sbuf_wdata,
        input  ti_clr,
        output txd,
        output ti,
        output busy
    );

endinterface

// File: rtl/uart_tx_8051_baud_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1 while a frame runs and pulses tick on the
// last count so the FSM advances exactly every CLK_DIV cycles.
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned DIV_W   = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clock) begin
        if (reset || restart || !run) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = run && (div_cnt == DIV_LAST);

endmodule

// File: rtl/uart_tx_8051.sv
// 8051 serial-port transmitter, SCON mode 1 (8N1); with UART_TB8_EN an 11-bit frame
// carrying TB8 after data bit 7. All outputs come straight from registers.
module uart_tx_8051
    import uart8051_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned DIV_W   = 10
) (
    input logic           clock,
    input logic           reset,
    uart_tx_8051_if.slave tx
);

    tx_state_e  state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       txd_q;
    logic       ti_q;
    logic       busy_q;
`ifdef UART_TB8_EN
    logic       tb8_q;
`endif

    logic tick;
    logic restart;

    assign restart = (state == IDLE) && tx.sbuf_we;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .run     (busy_q),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            txd_q     <= TXD_IDLE;
            ti_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TB8_EN
            tb8_q     <= 1'b0;
`endif
        end else begin
            // A TI set later in this block overrides the clear in the same cycle.
            if (tx.ti_clr) begin
                ti_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    txd_q <= TXD_IDLE;
                    if (tx.sbuf_we) begin
                        shift_reg <= tx.sbuf_wdata;
`ifdef UART_TB8_EN
                        tb8_q     <= tx.tb8;
`endif
                        bit_cnt   <= '0;
                        state     <= START;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        state     <= DATA;
                        txd_q     <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= '0;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TB8_EN
                            state <= TB8;
                            txd_q <= tb8_q;
`else
                            state <= STOP;
                            txd_q <= 1'b1;
                            ti_q  <= 1'b1;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            txd_q     <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end
                end

`ifdef UART_TB8_EN
                TB8: begin
                    if (tick) begin
                        state <= STOP;
                        txd_q <= 1'b1;
                        ti_q  <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        txd_q  <= TXD_IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    txd_q  <= TXD_IDLE;
                end
            endcase
        end
    end

    assign tx.txd  = txd_q;
    assign tx.ti   = ti_q;
    assign tx.busy = busy_q;

endmodule

// File: tb/tb_uart_tx_8051.sv
// Directed bench for uart_tx_8051 with CLK_DIV=4; edge numbers count from the edge
// that samples sbuf_we (edge 0). Honours UART_TB8_EN for the 11-bit frame.
module tb_uart_tx_8051;

    localparam int CLK_DIV = 4;
`ifdef UART_TB8_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int SET_E = (NB - 1) * CLK_DIV;   // edge entering STOP (TI set)
    localparam int END_E = NB * CLK_DIV;         // edge returning to IDLE

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    uart_tx_8051_if bus();

    uart_tx_8051 #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tx    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; values seen afterwards are the spec's "at next edge" values.
    task automatic step();
        @(posedge clock);
        #1;
        bus.sbuf_we = 1'b0;
        bus.ti_clr  = 1'b0;
    endtask

    task automatic set_tb8(input logic v);
`ifdef UART_TB8_EN
        bus.tb8 = v;
`else
        if (v) begin end
`endif
    endtask

    // bits[i] is the line value of frame bit i (0 = start). A write of 0xFF is offered
    // at inj_edge and again on the busy-falling edge; both must be dropped.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic tb8v,
                             input logic [10:0] bits, input int inj_edge,
                             input int clr_a, input int clr_b, input int n,
                             input logic ti_pre);
        logic ti_exp;
        logic txd_exp;
        ti_exp = ti_pre;
        bus.sbuf_we    = 1'b1;
        bus.sbuf_wdata = d;
        set_tb8(tb8v);
        for (int e = 1; e <= n; e++) begin
            step();
            if (e - 1 == SET_E) ti_exp = 1'b1;
            else if (e - 1 == clr_a || e - 1 == clr_b) ti_exp = 1'b0;
            txd_exp = (e <= END_E) ? bits[(e - 1) / CLK_DIV] : 1'b1;
            check($sformatf("%s txd@%0d", tag, e), 32'(bus.txd), 32'(txd_exp));
            check($sformatf("%s busy@%0d", tag, e), 32'(bus.busy), 32'(e <= END_E));
            check($sformatf("%s ti@%0d", tag, e), 32'(bus.ti), 32'(ti_exp));
            if (e == inj_edge || e == END_E) begin
                bus.sbuf_we    = 1'b1;
                bus.sbuf_wdata = 8'hFF;
                set_tb8(~tb8v);
            end
            if (e == clr_a || e == clr_b) bus.ti_clr = 1'b1;
        end
    endtask

    initial begin
        bus.sbuf_we    = 1'b0;
        bus.sbuf_wdata = 8'h00;
        bus.ti_clr     = 1'b0;
        set_tb8(1'b0);

        // Reset held for three edges, then twenty idle cycles.
        repeat (3) step();
        check("rst txd", 32'(bus.txd), 32'd1);
        check("rst ti", 32'(bus.ti), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle txd@%0d", i), 32'(bus.txd), 32'd1);
            check($sformatf("idle ti@%0d", i), 32'(bus.ti), 32'd0);
            check($sformatf("idle busy@%0d", i), 32'(bus.busy), 32'd0);
        end

        // 0x55 with ti_clr on the TI-set edge (set wins) and again 14 edges later.
        run_frame("f55", 8'h55, 1'b1, 11'b1_1_01010101_0, -1,
                  SET_E, SET_E + 14, SET_E + 17, 1'b0);

        // 0xA3 with a dropped 0xFF write mid-frame.
        run_frame("fA3", 8'hA3, 1'b1, 11'b1_1_10100011_0, 10,
                  -1, -1, END_E + 3, 1'b0);

        // 0x00 frame aborted by reset sampled at edge 20.
        bus.sbuf_we    = 1'b1;
        bus.sbuf_wdata = 8'h00;
        set_tb8(1'b0);
        for (int e = 1; e <= 20; e++) begin
            step();
            check($sformatf("f00 txd@%0d", e), 32'(bus.txd), 32'd0);
            check($sformatf("f00 busy@%0d", e), 32'(bus.busy), 32'd1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort txd", 32'(bus.txd), 32'd1);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ti", 32'(bus.ti), 32'd0);

        run_frame("f3C", 8'h3C, 1'b1, 11'b1_1_00111100_0, -1,
                  -1, -1, END_E + 3, 1'b0);

        // TI stays set from the previous frame across this one.
        run_frame("f81", 8'h81, 1'b1, 11'b1_1_10000001_0, -1,
                  -1, -1, END_E + 3, 1'b1);
`ifdef UART_TB8_EN
        run_frame("f81t0", 8'h81, 1'b0, 11'b1_0_10000001_0, -1,
                  -1, -1, END_E + 3, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
